player_ctrl: RTL and testbench

//  Parametrised player-ship controller, clocked once per video frame. Decodes up to NUM_KEYS

---
 rtl/player_ctrl_if.sv | 21 ++
 rtl/player_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_player_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/player_ctrl_if.sv
// Shot request channel between the player controller and the bullet engine.
// The master raises a shot and holds it until the engine takes it.
interface player_ctrl_if #(
  parameter int W = 10
);
  logic         fire_valid;
  logic         fire_ready;
  logic [W-1:0] fire_x;

  modport master (
    output fire_valid,
    output fire_x,
    input  fire_ready
  );

  modport slave (
    input  fire_valid,
    input  fire_x,
    output fire_ready
  );
endinterface

// File: rtl/player_ctrl.sv
// Player ship controller: key decode, clamped motion, cooldown-limited fire
// and a lives state machine, all advanced once per video frame.
module player_ctrl #(
  parameter int          W         = 10,
  parameter int          NUM_KEYS  = 4,
  parameter int          X_MIN     = 0,
  parameter int          X_MAX     = 639,
  parameter int          X_CENTER  = 320,
  parameter int          STEP      = 1,
  parameter int          SIZE      = 4,
  parameter logic [7:0]  KEY_LEFT  = 8'h04,
  parameter logic [7:0]  KEY_RIGHT = 8'h07,
  parameter logic [7:0]  KEY_FIRE  = 8'h2C,
  parameter bit          AUTOFIRE  = 1'b0,
  parameter int          COOLDOWN  = 16,
  parameter int          LIVES     = 3,
  parameter int          DEATH_FR  = 60
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic [8*NUM_KEYS-1:0] keycodes,
  input  logic                  enable,
  input  logic                  hit,
  player_ctrl_if.master         fire,
  output logic [W-1:0]          player_x,
  output logic [W-1:0]          player_s,
  output logic                  visible,
  output logic [2:0]            lives,
  output logic                  game_over
);

  localparam int TR = $clog2(DEATH_FR + 1);
  localparam int TW = (TR < 3) ? 3 : TR;
  localparam int CW = $clog2(COOLDOWN + 1);

  localparam logic [W:0] X_LO = (W+1)'(X_MIN + SIZE);
  localparam logic [W:0] X_HI = (W+1)'(X_MAX - SIZE);
  localparam logic [W:0] STP  = (W+1)'(STEP);

  typedef enum logic [1:0] {
    ALIVE,
    DYING,
    RESPAWN,
    GAME_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  fx_q, fx_d;
  logic [2:0]    lives_q, lives_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cd_q, cd_d;
  logic          fv_q, fv_d;
  logic          fprev_q, fprev_d;

  logic          key_l, key_r, key_f;
  logic          trig, xfer, can_move;
  logic [W:0]    x_w, x_left, x_right;

  always_comb begin
    key_l = 1'b0;
    key_r = 1'b0;
    key_f = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      key_l = key_l | (keycodes[8*k +: 8] == KEY_LEFT);
      key_r = key_r | (keycodes[8*k +: 8] == KEY_RIGHT);
      key_f = key_f | (keycodes[8*k +: 8] == KEY_FIRE);
    end
  end

  // One extra bit keeps the clamp exact near both ends of the range.
  always_comb begin
    x_w     = {1'b0, x_q};
    x_left  = (x_w < X_LO + STP) ? X_LO : x_w - STP;
    x_right = (x_w + STP > X_HI) ? X_HI : x_w + STP;
  end

  assign trig     = AUTOFIRE ? key_f : (key_f & ~fprev_q);
  assign xfer     = fv_q & fire.fire_ready;
  assign can_move = (state_q == ALIVE) || (state_q == RESPAWN);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    fx_d    = fx_q;
    lives_d = lives_q;
    timer_d = timer_q;
    cd_d    = cd_q;
    fv_d    = fv_q;
    fprev_d = fprev_q;

    // The engine may take a pending shot even while paused.
    if (xfer) begin
      fv_d = 1'b0;
      cd_d = CW'(COOLDOWN);
    end

    if (enable) begin
      fprev_d = key_f;
      if (!xfer && cd_q != '0)
        cd_d = cd_q - CW'(1);

      if (can_move) begin
        unique case (1'b1)
          (key_l & ~key_r): x_d = x_left[W-1:0];
          (key_r & ~key_l): x_d = x_right[W-1:0];
          default: ;
        endcase
        if (!fv_q && cd_q == '0 && trig) begin
          fv_d = 1'b1;
          fx_d = x_q;
        end
      end

      unique case (state_q)
        ALIVE: begin
          if (hit) begin
            lives_d = lives_q - 3'd1;
            fv_d    = 1'b0;
            timer_d = TW'(DEATH_FR);
            state_d = (lives_q > 3'd1) ? DYING : GAME_OVER;
          end
        end
        DYING: begin
          if (timer_q == TW'(1)) begin
            x_d     = W'(X_CENTER);
            cd_d    = '0;
            timer_d = TW'(DEATH_FR);
            state_d = RESPAWN;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        RESPAWN: begin
          if (timer_q == TW'(1))
            state_d = ALIVE;
          else
            timer_d = timer_q - TW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ALIVE;
      x_q     <= W'(X_CENTER);
      fx_q    <= W'(X_CENTER);
      lives_q <= 3'(LIVES);
      timer_q <= '0;
      cd_q    <= '0;
      fv_q    <= 1'b0;
      fprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      fx_q    <= fx_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
      cd_q    <= cd_d;
      fv_q    <= fv_d;
      fprev_q <= fprev_d;
    end
  end

  always_comb begin
    unique case (state_q)
      ALIVE:           visible = 1'b1;
      DYING, RESPAWN:  visible = timer_q[2];
      default:         visible = 1'b0;
    endcase
  end

  assign fire.fire_valid = fv_q;
  assign fire.fire_x     = fx_q;
  assign player_x        = x_q;
  assign player_s        = W'(SIZE);
  assign lives           = lives_q;
  assign game_over       = (state_q == GAME_OVER);

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios then random frames,
// every frame compared against a frame-level reference model.
module tb_player_ctrl;

  localparam int W      = 10;
  localparam int NK     = 4;
  localparam int LO     = 4;
  localparam int HI     = 635;
  localparam int CENTER = 320;
  localparam int CDN    = 16;
  localparam int DFR    = 60;

  logic              frame_clk = 1'b0;
  logic              Reset_n   = 1'b0;
  logic [8*NK-1:0]   keycodes  = '0;
  logic              enable    = 1'b1;
  logic              hit       = 1'b0;
  logic [W-1:0]      player_x;
  logic [W-1:0]      player_s;
  logic              visible;
  logic [2:0]        lives;
  logic              game_over;
  logic [7:0]        slot [NK];

  int n_run  = 0;
  int n_fail = 0;

  int m_x, m_fx, m_lives, m_mode, m_left, m_cd, m_fv, m_fprev;

  always #5 frame_clk = ~frame_clk;

  player_ctrl_if #(.W(W)) fire_bus ();

  player_ctrl #(.W(W), .NUM_KEYS(NK)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycodes  (keycodes),
    .enable    (enable),
    .hit       (hit),
    .fire      (fire_bus),
    .player_x  (player_x),
    .player_s  (player_s),
    .visible   (visible),
    .lives     (lives),
    .game_over (game_over)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 alive, 1 dying, 2 respawn, 3 game over
  task automatic m_reset();
    m_x = CENTER; m_fx = CENTER; m_lives = 3; m_mode = 0;
    m_left = 0; m_cd = 0; m_fv = 0; m_fprev = 0;
  endtask

  task automatic m_step();
    bit l, r, f, xfer, trig;
    int x0, cd0, fv0;
    l = 0; r = 0; f = 0;
    for (int k = 0; k < NK; k++) begin
      if (slot[k] == 8'h04) l = 1;
      if (slot[k] == 8'h07) r = 1;
      if (slot[k] == 8'h2C) f = 1;
    end
    x0 = m_x; cd0 = m_cd; fv0 = m_fv;
    xfer = (fv0 == 1) && (fire_bus.fire_ready == 1'b1);
    if (xfer) begin m_fv = 0; m_cd = CDN; end
    if (!enable) return;
    trig = f && !m_fprev;
    m_fprev = f;
    if (!xfer) m_cd = (cd0 > 0) ? cd0 - 1 : 0;
    if (m_mode == 0 || m_mode == 2) begin
      if (l && !r) m_x = (x0 - 1 < LO) ? LO : x0 - 1;
      if (r && !l) m_x = (x0 + 1 > HI) ? HI : x0 + 1;
      if (fv0 == 0 && cd0 == 0 && trig) begin m_fv = 1; m_fx = x0; end
    end
    case (m_mode)
      0: if (hit) begin
           m_lives--; m_fv = 0;
           if (m_lives == 0) m_mode = 3;
           else begin m_mode = 1; m_left = DFR; end
         end
      1: if (m_left == 1) begin
           m_x = CENTER; m_cd = 0; m_mode = 2; m_left = DFR;
         end else m_left--;
      2: if (m_left == 1) m_mode = 0; else m_left--;
      default: ;
    endcase
  endtask

  task automatic check_all();
    int vis;
    vis = (m_mode == 0) ? 1 : (m_mode == 3) ? 0 : (m_left >> 2) & 1;
    chk("player_x",   player_x,            m_x);
    chk("lives",      lives,               m_lives);
    chk("fire_valid", fire_bus.fire_valid, m_fv);
    chk("fire_x",     fire_bus.fire_x,     m_fx);
    chk("visible",    visible,             vis);
    chk("game_over",  game_over,           (m_mode == 3) ? 1 : 0);
    chk("player_s",   player_s,            4);
  endtask

  task automatic frame();
    keycodes = {slot[3], slot[2], slot[1], slot[0]};
    @(posedge frame_clk);
    m_step();
    @(negedge frame_clk);
    check_all();
  endtask

  // Asserted and released between clock edges.
  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1 m_reset();
    check_all();
    #1 Reset_n = 1'b1;
  endtask

  task automatic clear_keys();
    for (int k = 0; k < NK; k++) slot[k] = 8'h00;
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom % 6)
      0, 1:    return 8'h00;
      2:       return 8'h04;
      3:       return 8'h07;
      4:       return 8'h2C;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int cnt, xp, fxs, xg;
    clear_keys();
    fire_bus.fire_ready = 1'b0;

    // reset mid-frame
    #12 m_reset();
    check_all();
    #1 Reset_n = 1'b1;
    frame();

    // right clamp, both keys, left clamp
    slot[2] = 8'h07;
    repeat (400) frame();
    chk("x_clamp_hi", player_x, HI);
    slot[0] = 8'h04;
    repeat (8) frame();
    chk("x_frozen_lr", player_x, HI);
    slot[2] = 8'h00;
    repeat (640) frame();
    chk("x_clamp_lo", player_x, LO);

    // single shot on press edge, cooldown blocks re-press
    clear_keys();
    fire_bus.fire_ready = 1'b1;
    frame();
    xp = player_x; cnt = 0; fxs = -1;
    slot[1] = 8'h2C;
    repeat (5) begin
      frame();
      if (fire_bus.fire_valid) begin cnt++; fxs = fire_bus.fire_x; end
    end
    chk("one_shot", cnt, 1);
    chk("fire_x_press", fxs, xp);
    slot[1] = 8'h00; frame();
    slot[1] = 8'h2C; cnt = 0;
    repeat (3) begin
      frame();
      if (fire_bus.fire_valid) cnt++;
    end
    chk("cd_block", cnt, 0);

    // held request while engine busy
    slot[1] = 8'h00;
    repeat (20) frame();
    fire_bus.fire_ready = 1'b0;
    xp = player_x;
    slot[1] = 8'h2C;
    frame();
    chk("refire", fire_bus.fire_valid, 1);
    chk("fire_x_2", fire_bus.fire_x, xp);
    slot[0] = 8'h07;
    repeat (5) begin
      frame();
      chk("hold_valid", fire_bus.fire_valid, 1);
      chk("hold_x", fire_bus.fire_x, xp);
    end
    fire_bus.fire_ready = 1'b1;
    frame();
    chk("xfer_drop", fire_bus.fire_valid, 0);
    clear_keys();
    repeat (15) frame();
    slot[1] = 8'h2C; frame();
    chk("cd_edge_block", fire_bus.fire_valid, 0);
    slot[1] = 8'h00; frame();
    slot[1] = 8'h2C; frame();
    chk("cd_expired", fire_bus.fire_valid, 1);
    clear_keys(); frame();

    // hit, dying, respawn invulnerability
    do_reset();
    slot[2] = 8'h07;
    repeat (10) frame();
    clear_keys();
    hit = 1'b1; frame(); hit = 1'b0;
    chk("lives_after_hit", lives, 2);
    slot[2] = 8'h07;
    repeat (60) frame();
    chk("respawn_x", player_x, CENTER);
    clear_keys();
    hit = 1'b1;
    repeat (10) frame();
    hit = 1'b0;
    chk("respawn_invuln", lives, 2);
    repeat (55) frame();
    chk("alive_visible", visible, 1);

    // run out of lives
    repeat (2) begin
      hit = 1'b1; frame(); hit = 1'b0;
      repeat (125) frame();
    end
    chk("game_over", game_over, 1);
    chk("lives_zero", lives, 0);
    xg = player_x;
    slot[0] = 8'h07; slot[3] = 8'h2C;
    fire_bus.fire_ready = 1'b1;
    repeat (20) frame();
    chk("go_frozen", player_x, xg);
    chk("go_no_fire", fire_bus.fire_valid, 0);

    // random frames
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NK; k++) slot[k] = pick_key();
      enable = ($urandom % 8) != 0;
      hit = ($urandom % 50) == 0;
      fire_bus.fire_ready = ($urandom % 3) != 0;
      frame();
      if ((game_over && ($urandom % 20) == 0) || (i % 500 == 499))
        do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
